// File: rtl/int_mul_pkg.sv
// Shared types for the variable-latency iterative multiplier.
// Mode and FSM state encodings plus small width helpers.
package int_mul_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_MUL    = 2'd0,
        MODE_MULH   = 2'd1,
        MODE_MULHSU = 2'd2,
        MODE_MULHU  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic int msg_width(input int nbits);
        return MODE_W + 2 * nbits;
    endfunction

endpackage

// File: rtl/int_mul_var_dpath.sv
// Datapath: operand magnitudes, shift-add accumulator, zero skipping,
// and the final sign fix-up and high/low half select.
module int_mul_var_dpath
    import int_mul_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_skip_max = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_i,
    input  logic                            add_i,
    input  logic                            skip_i,
    input  logic                            done_i,
    input  logic [msg_width(p_nbits)-1:0]   msg_i,
    output logic                            b_is_zero_next_o,
    output logic                            b_lsb_o,
    output logic [p_nbits-1:0]              result_o
);

    localparam int N    = p_nbits;
    localparam int W    = 2 * N;
    localparam int SKIP = (p_skip_max < N) ? p_skip_max : N;
    localparam int KW   = $clog2(SKIP + 1);

    mode_e          mode;
    logic [N-1:0]   a_in, b_in, a_abs, b_abs;
    logic           a_sgn, b_sgn;
    logic [KW-1:0]  k;
    logic [W-1:0]   a_q, a_d, acc_q, acc_d, prod;
    logic [N-1:0]   b_q, b_d;
    logic           neg_q, neg_d, hi_q, hi_d;

    assign mode  = mode_e'(msg_i[W+1:W]);
    assign a_in  = msg_i[W-1:N];
    assign b_in  = msg_i[N-1:0];
    assign a_sgn = (mode != MODE_MULHU) & a_in[N-1];
    assign b_sgn = ((mode == MODE_MUL) | (mode == MODE_MULH)) & b_in[N-1];
    // Magnitudes stay N-bit unsigned so the most-negative value fits.
    assign a_abs = a_sgn ? (~a_in + 1'b1) : a_in;
    assign b_abs = b_sgn ? (~b_in + 1'b1) : b_in;

    // Zero-run length at the bottom of b, capped so a set bit is never crossed.
    always_comb begin
        k = KW'(SKIP);
        for (int i = SKIP - 1; i >= 0; i--) begin
            if (b_q[i]) k = KW'(i);
        end
    end

    // Next-state for the datapath registers: load, add-step or skip-step.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        neg_d = neg_q;
        hi_d  = hi_q;
        if (load_i) begin
            a_d   = {{N{1'b0}}, a_abs};
            b_d   = b_abs;
            acc_d = '0;
            neg_d = a_sgn ^ b_sgn;
            hi_d  = (mode != MODE_MUL);
        end else if (add_i) begin
            acc_d = acc_q + a_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
        end else if (skip_i) begin
            a_d   = a_q << k;
            b_d   = b_q >> k;
        end
    end

    // Datapath register bank, cleared on reset so an abort leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
            hi_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            neg_q <= neg_d;
            hi_q  <= hi_d;
        end
    end

    assign b_is_zero_next_o = (b_d == '0);
    assign b_lsb_o          = b_q[0];

    // Sign fix-up then half select; result reads zero outside DONE.
    always_comb begin
        prod     = neg_q ? (~acc_q + 1'b1) : acc_q;
        result_o = '0;
        if (done_i) result_o = hi_q ? prod[W-1:N] : prod[N-1:0];
    end

endmodule

// File: rtl/int_mul_var_iter.sv
// Iterative shift-add multiplier with early termination and zero skipping.
// Control FSM and val/rdy handshakes; arithmetic lives in the datapath.
module int_mul_var_iter
    import int_mul_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_skip_max = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            istream_val,
    output logic                            istream_rdy,
    input  logic [msg_width(p_nbits)-1:0]   istream_msg,
    output logic                            ostream_val,
    input  logic                            ostream_rdy,
    output logic [p_nbits-1:0]              ostream_msg
);

    state_e state_q, state_d;
    logic   load, add, skip, done;
    logic   b_zero_nxt, b_lsb;

    int_mul_var_dpath #(
        .p_nbits    (p_nbits),
        .p_skip_max (p_skip_max)
    ) u_dpath (
        .clk              (clk),
        .reset            (reset),
        .load_i           (load),
        .add_i            (add),
        .skip_i           (skip),
        .done_i           (done),
        .msg_i            (istream_msg),
        .b_is_zero_next_o (b_zero_nxt),
        .b_lsb_o          (b_lsb),
        .result_o         (ostream_msg)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, datapath controls and handshake outputs.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        add         = 1'b0;
        skip        = 1'b0;
        done        = 1'b0;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        case (state_q)
            S_IDLE: begin
                istream_rdy = reset;
                if (istream_val && reset) begin
                    load    = 1'b1;
                    state_d = b_zero_nxt ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                add  = b_lsb;
                skip = ~b_lsb;
                if (b_zero_nxt) state_d = S_DONE;
            end
            S_DONE: begin
                ostream_val = 1'b1;
                done        = 1'b1;
                if (ostream_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_int_mul_var_iter.sv
// Directed and random checks for int_mul_var_iter.
// N=32, p_skip_max=4.
module tb_int_mul_var_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        istream_val = 1'b0;
    logic        istream_rdy;
    logic [65:0] istream_msg = '0;
    logic        ostream_val;
    logic        ostream_rdy = 1'b0;
    logic [31:0] ostream_msg;

    int errors = 0;
    int checks = 0;

    int_mul_var_iter #(
        .p_nbits    (32),
        .p_skip_max (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [1:0] m,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, p;
        sa = (m == 2'd3) ? {32'b0, a} : {{32{a[31]}}, a};
        sb = (m <= 2'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = sa * sb;
        return (m == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    // Drive one request and collect the result; called at posedge+1.
    task automatic run_txn(input logic [1:0] m, input logic [31:0] a,
                           input logic [31:0] b, input int stall,
                           output logic [31:0] res, output int lat,
                           output bit to);
        int n;
        to = 1'b0;
        istream_msg = {m, a, b};
        istream_val = 1'b1;
        n = 0;
        while (!istream_rdy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        istream_val = 1'b0;
        lat = 1;
        while (!ostream_val && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        to = !ostream_val;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        res = ostream_msg;
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ostream_val !== 1'b0 || istream_rdy !== 1'b0 || ostream_msg !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs val=%b rdy=%b msg=%h want 0 0 0",
                     ostream_val, istream_rdy, ostream_msg);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (istream_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy got=%b want=1", istream_rdy);
        end
    endtask

    task automatic test_directed();
        logic [1:0]  m [10];
        logic [31:0] av [10], bv [10], ev [10];
        int          lv [10];
        logic [31:0] res;
        int          lat;
        bit          to;
        m[0]=2'd0; av[0]=32'd3;          bv[0]=32'd4;          ev[0]=32'hC;        lv[0]=3;
        m[1]=2'd0; av[1]=32'h12345678;   bv[1]=32'd0;          ev[1]=32'h0;        lv[1]=1;
        m[2]=2'd1; av[2]=32'hFFFFFFFB;   bv[2]=32'd0;          ev[2]=32'h0;        lv[2]=1;
        m[3]=2'd3; av[3]=32'hFFFFFFFF;   bv[3]=32'hFFFFFFFF;   ev[3]=32'hFFFFFFFE; lv[3]=33;
        m[4]=2'd0; av[4]=32'hFFFFFFFF;   bv[4]=32'hFFFFFFFF;   ev[4]=32'h1;        lv[4]=-1;
        m[5]=2'd1; av[5]=32'hFFFFFFFE;   bv[5]=32'd3;          ev[5]=32'hFFFFFFFF; lv[5]=3;
        m[6]=2'd0; av[6]=32'hFFFFFFFE;   bv[6]=32'd3;          ev[6]=32'hFFFFFFFA; lv[6]=3;
        m[7]=2'd1; av[7]=32'h80000000;   bv[7]=32'h80000000;   ev[7]=32'h40000000; lv[7]=10;
        m[8]=2'd2; av[8]=32'hFFFFFFFF;   bv[8]=32'h80000000;   ev[8]=32'hFFFFFFFF; lv[8]=10;
        m[9]=2'd3; av[9]=32'hFFFFFFFF;   bv[9]=32'h80000000;   ev[9]=32'h7FFFFFFF; lv[9]=10;
        for (int i = 0; i < 10; i++) begin
            run_txn(m[i], av[i], bv[i], 0, res, lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL dir%0d_timeout no ostream_val", i);
            end else if (res !== ev[i]) begin
                errors++;
                $display("FAIL dir%0d_msg got=%h want=%h", i, res, ev[i]);
            end
            if (lv[i] > 0) begin
                checks++;
                if (lat != lv[i]) begin
                    errors++;
                    $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, lv[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        istream_msg = {2'd0, 32'd5, 32'd3};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_msg = {2'd0, 32'd2, 32'd2};
        n = 0;
        while (!ostream_val && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ostream_val !== 1'b1 || ostream_msg !== 32'd15 || istream_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d val=%b msg=%h rdy=%b want 1 0000000f 0",
                         c, ostream_val, ostream_msg, istream_rdy);
            end
            @(posedge clk); #1;
        end
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_hs rdy=%b val=%b want 1 0", istream_rdy, ostream_val);
        end
        @(posedge clk); #1;
        istream_val = 1'b0;
        checks++;
        if (istream_rdy !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept rdy=%b want 0", istream_rdy);
        end
        n = 1;
        while (!ostream_val && n < 50) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (ostream_val !== 1'b1 || ostream_msg !== 32'd4 || n != 3) begin
            errors++;
            $display("FAIL bp_second_result val=%b msg=%h lat=%0d want 1 00000004 3",
                     ostream_val, ostream_msg, n);
        end
        ostream_rdy = 1'b1;
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] res;
        int          lat;
        bit          to;
        istream_msg = {2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ostream_val !== 1'b0 || istream_rdy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_low val=%b rdy=%b want 0 0", ostream_val, istream_rdy);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (istream_rdy !== 1'b1 || ostream_val !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle rdy=%b val=%b want 1 0", istream_rdy, ostream_val);
        end
        @(posedge clk); #1;
        run_txn(2'd0, 32'd7, 32'd6, 0, res, lat, to);
        checks++;
        if (to || res !== 32'd42 || lat != 4) begin
            errors++;
            $display("FAIL midreset_next to=%b msg=%h lat=%0d want 0 0000002a 4", to, res, lat);
        end
    endtask

    task automatic test_random();
        logic [1:0]  m;
        logic [31:0] a, b, exp, res;
        int          lat;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            m = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case (i % 4)
                0: b = b & 32'h0000_0F0F;
                1: a = a & 32'h0000_00FF;
                2: b = b & (32'h8000_0001 | (32'h1 << $urandom_range(0, 31)));
                default: ;
            endcase
            exp = ref_mul(m, a, b);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            run_txn(m, a, b, $urandom_range(0, 3), res, lat, to);
            checks++;
            if (to || res !== exp) begin
                errors++;
                $display("FAIL rand%0d mode=%0d a=%h b=%h got=%h want=%h to=%b",
                         i, m, a, b, res, exp, to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
